// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: owns the fetch PC, keeps at most one word request
// outstanding to instruction memory and fills the IF/ID output slot.
module ifu_fetch #(
  parameter int unsigned             INST_WIDTH = 32,
  parameter int unsigned             DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0]   RESET_PC   = 64'h8000_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  imem_req_valid_o,
  input  logic                  imem_req_ready_i,
  output logic [DATA_WIDTH-1:0] imem_req_addr_o,
  input  logic                  imem_rsp_valid_i,
  input  logic [INST_WIDTH-1:0] imem_rsp_data_i,
  output logic                  valid_o,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [DATA_WIDTH-1:0] pc_o
);

  typedef enum logic {
    ST_REQ  = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

  state_e                state_q, state_d;
  logic                  kill_q, kill_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  valid_q, valid_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic [DATA_WIDTH-1:0] pc_out_q, pc_out_d;

  logic slot_free;
  logic req_fire;

  // Request handshake: a transfer happens at a posedge where valid and ready
  // are both high. Valid is only raised when the output slot will be free, so
  // the single response can always be written without overwriting a live slot.
  assign slot_free        = !valid_q || !stall_i;
  assign imem_req_valid_o = (state_q == ST_REQ) && slot_free;
  assign imem_req_addr_o  = pc_q & ALIGN_MASK;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;

  always_comb begin
    state_d  = state_q;
    kill_d   = kill_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    inst_d   = inst_q;
    pc_out_d = pc_out_q;

    if (valid_q && !stall_i) begin
      valid_d = 1'b0;
    end

    if (redirect_i) begin
      pc_d    = redirect_pc_i & ALIGN_MASK;
      valid_d = 1'b0;
      unique case (state_q)
        ST_REQ: begin
          if (req_fire) begin
            state_d = ST_WAIT;
            kill_d  = 1'b1;
          end
        end
        ST_WAIT: begin
          // A response landing on the redirect cycle belongs to the old path.
          if (imem_rsp_valid_i) begin
            state_d = ST_REQ;
            kill_d  = 1'b0;
          end else begin
            kill_d  = 1'b1;
          end
        end
        default: state_d = ST_REQ;
      endcase
    end else begin
      unique case (state_q)
        ST_REQ: begin
          if (req_fire) begin
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid_i) begin
            state_d = ST_REQ;
            if (kill_q) begin
              kill_d = 1'b0;
            end else begin
              inst_d   = imem_rsp_data_i;
              pc_out_d = pc_q;
              valid_d  = 1'b1;
              pc_d     = pc_q + DATA_WIDTH'(4);
            end
          end
        end
        default: state_d = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_REQ;
      kill_q   <= 1'b0;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      inst_q   <= '0;
      pc_out_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      kill_q   <= kill_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      inst_q   <= inst_d;
      pc_out_q <= pc_out_d;
    end
  end

  assign valid_o = valid_q;
  assign inst_o  = inst_q;
  assign pc_o    = pc_out_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed, table-driven bench for ifu_fetch: each row drives one cycle of
// inputs and lists the outputs expected during that cycle.
module tb_ifu_fetch;

  localparam logic [63:0] R  = 64'h8000_0000;
  localparam logic [63:0] TP = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        valid;
  logic [31:0] inst;
  logic [63:0] pc;

  ifu_fetch #(
    .INST_WIDTH(32),
    .DATA_WIDTH(64),
    .RESET_PC  (64'h8000_0000)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .stall_i         (stall),
    .redirect_i      (redirect),
    .redirect_pc_i   (redirect_pc),
    .imem_req_valid_o(req_valid),
    .imem_req_ready_i(req_ready),
    .imem_req_addr_o (req_addr),
    .imem_rsp_valid_i(rsp_valid),
    .imem_rsp_data_i (rsp_data),
    .valid_o         (valid),
    .inst_o          (inst),
    .pc_o            (pc)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [63:0] rpc;
    logic        rdy;
    logic        rsp;
    logic [31:0] rdata;
    logic        e_rv;
    logic [63:0] e_ra;
    logic        e_v;
    logic [63:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          tests;
  int          fails;
  logic        prev_valid;

  function automatic vec_t row(input logic s, input logic rd, input logic [63:0] rpc,
                               input logic rdy, input logic rsp, input logic [31:0] rdata,
                               input logic e_rv, input logic [63:0] e_ra, input logic e_v,
                               input logic [63:0] e_pc, input logic [31:0] e_inst);
    vec_t v;
    v.rst = 1'b1; v.stall = s; v.redir = rd; v.rpc = rpc; v.rdy = rdy;
    v.rsp = rsp; v.rdata = rdata; v.e_rv = e_rv; v.e_ra = e_ra; v.e_v = e_v;
    v.e_pc = e_pc; v.e_inst = e_inst;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // scoreboard: every fresh rise of valid_o must deliver the next expected word
  task automatic score(input int idx);
    logic [31:0] e;
    if (valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL deliver step %0d: got %h expected no delivery", idx, inst);
      end else begin
        e = exp_q.pop_front();
        chk("deliver", idx, 64'(inst), 64'(e));
      end
    end
    prev_valid = valid;
  endtask

  // driver: apply a row at the falling edge, check just after it settles
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst_n       = v.rst;
    stall       = v.stall;
    redirect    = v.redir;
    redirect_pc = v.rpc;
    req_ready   = v.rdy;
    rsp_valid   = v.rsp;
    rsp_data    = v.rdata;
    #1;
    chk("req_valid", idx, 64'(req_valid), 64'(v.e_rv));
    chk("req_addr",  idx, req_addr, v.e_ra);
    chk("valid",     idx, 64'(valid), 64'(v.e_v));
    chk("pc",        idx, pc, v.e_pc);
    chk("inst",      idx, 64'(inst), 64'(v.e_inst));
    score(idx);
  endtask

  initial begin
    vec_t h;
    tests = 0;
    fails = 0;
    prev_valid = 1'b0;
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;

    exp_q.push_back(32'h13);       exp_q.push_back(32'h13);
    exp_q.push_back(32'h0010_0093); exp_q.push_back(32'h11);
    exp_q.push_back(32'h22);       exp_q.push_back(32'h33);
    exp_q.push_back(32'h44);       exp_q.push_back(32'h55);
    exp_q.push_back(32'h77);

    // 1-cycle memory, no stall
    vecs.push_back(row(0,0,0, 1,0,0,            1,R,      0,R,    0));
    vecs.push_back(row(0,0,0, 0,1,32'h13,       0,R,      0,R,    0));
    vecs.push_back(row(0,0,0, 1,0,0,            1,R+4,    1,R,    32'h13));
    vecs.push_back(row(0,0,0, 0,1,32'h13,       0,R+4,    0,R,    32'h13));
    vecs.push_back(row(0,0,0, 1,0,0,            1,R+8,    1,R+4,  32'h13));
    // response lands under stall, stall held five more cycles
    vecs.push_back(row(1,0,0, 0,1,32'h0010_0093, 0,R+8,   0,R+4,  32'h13));
    for (int i = 0; i < 5; i++)
      vecs.push_back(row(1,0,0, 1,0,0,          0,R+12,   1,R+8,  32'h0010_0093));
    vecs.push_back(row(0,0,0, 1,0,0,            1,R+12,   1,R+8,  32'h0010_0093));
    vecs.push_back(row(0,0,0, 0,1,32'h11,       0,R+12,   0,R+8,  32'h0010_0093));
    // redirect while waiting on a 3-cycle response
    vecs.push_back(row(0,0,0, 1,0,0,            1,R+16,   1,R+12, 32'h11));
    vecs.push_back(row(0,1,64'h8000_1002, 0,0,0, 0,R+16,  0,R+12, 32'h11));
    vecs.push_back(row(0,0,0, 0,0,0,            0,64'h8000_1000, 0,R+12, 32'h11));
    vecs.push_back(row(0,0,0, 0,1,32'hDEAD_0001, 0,64'h8000_1000, 0,R+12, 32'h11));
    vecs.push_back(row(0,0,0, 1,0,0,            1,64'h8000_1000, 0,R+12, 32'h11));
    vecs.push_back(row(0,0,0, 0,1,32'h22,       0,64'h8000_1000, 0,R+12, 32'h11));
    // redirect on the response cycle
    vecs.push_back(row(0,0,0, 1,0,0,            1,64'h8000_1004, 1,64'h8000_1000, 32'h22));
    vecs.push_back(row(0,1,64'h8000_2000, 0,1,32'hBAD, 0,64'h8000_1004, 0,64'h8000_1000, 32'h22));
    vecs.push_back(row(0,0,0, 1,0,0,            1,64'h8000_2000, 0,64'h8000_1000, 32'h22));
    vecs.push_back(row(0,0,0, 0,1,32'h33,       0,64'h8000_2000, 0,64'h8000_1000, 32'h22));
    // redirect on the acceptance cycle
    vecs.push_back(row(0,1,64'h8000_3008, 1,0,0, 1,64'h8000_2004, 1,64'h8000_2000, 32'h33));
    vecs.push_back(row(0,0,0, 0,1,32'hBAD2,     0,64'h8000_3008, 0,64'h8000_2000, 32'h33));
    vecs.push_back(row(0,0,0, 1,0,0,            1,64'h8000_3008, 0,64'h8000_2000, 32'h33));
    vecs.push_back(row(0,0,0, 0,1,32'h44,       0,64'h8000_3008, 0,64'h8000_2000, 32'h33));
    // redirect without acceptance, unaligned target, then PC wrap
    vecs.push_back(row(0,1,64'hFFFF_FFFF_FFFF_FFFF, 0,0,0, 1,64'h8000_300C, 1,64'h8000_3008, 32'h44));
    vecs.push_back(row(0,0,0, 1,0,0,            1,TP,     0,64'h8000_3008, 32'h44));
    vecs.push_back(row(0,0,0, 0,1,32'h55,       0,TP,     0,64'h8000_3008, 32'h44));
    vecs.push_back(row(0,0,0, 0,0,0,            1,64'h0,  1,TP,   32'h55));
    vecs.push_back(row(0,0,0, 1,0,0,            1,64'h0,  0,TP,   32'h55));
    vecs.push_back(row(0,0,0, 0,0,0,            0,64'h0,  0,TP,   32'h55));

    // initial reset
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", -1, 64'(valid), 64'd0);
    chk("rst_pc",    -1, pc, R);
    chk("rst_inst",  -1, 64'(inst), 64'd0);

    foreach (vecs[i]) apply(vecs[i], i);

    // reset while a request is outstanding; the late response must be ignored
    h = row(0,0,0, 0,0,0, 0,64'h0, 0,TP, 32'h55);
    h.rst = 1'b0;
    apply(h, 100);
    apply(row(0,0,0, 0,1,32'h66, 1,R,   0,R, 0), 101);
    apply(row(0,0,0, 1,0,0,      1,R,   0,R, 0), 102);
    apply(row(0,0,0, 0,1,32'h77, 0,R,   0,R, 0), 103);
    apply(row(0,0,0, 0,0,0,      1,R+4, 1,R, 32'h77), 104);

    chk("deliveries_left", 105, 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
